// File: rtl/rv32i_types.sv
// Shared fetch-stage types.
//   fetch_state_t   : fetch sequencer FSM states (IDLE, WAIT, SQUASH)
//   FETCH_BLK_BYTES : default fetch-block size in bytes (4 words of 4 bytes)
//   word_offset()   : word index of an address inside its fetch block
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SQUASH = 2'd2
    } fetch_state_t;

    localparam int FETCH_BLK_BYTES = 16;

    // Word index of addr within a block of fetch_width words (fetch_width is a power of two).
    function automatic logic [3:0] word_offset(input logic [31:0] addr, input int fetch_width);
        return 4'((addr >> 2) & 32'(fetch_width - 1));
    endfunction

endpackage

// File: rtl/fetch_align.sv
// Aligns a returned fetch block to the requested PC and decides how many words to push.
// Ports:
//   rdata : returned block, word i at bits [32i+31:32i]
//   off   : word offset of the requested PC inside the block
//   space : free instruction-queue entries
//   take  : words to push = min(FETCH_WIDTH - off, min(space, FETCH_WIDTH))
//   data  : rdata shifted down by off words, words at and above take forced to zero
module fetch_align #(
    parameter int FETCH_WIDTH = 4,
    parameter int SPACE_W     = 4
) (
    input  logic [32*FETCH_WIDTH-1:0] rdata,
    input  logic [3:0]                off,
    input  logic [SPACE_W-1:0]        space,
    output logic [3:0]                take,
    output logic [32*FETCH_WIDTH-1:0] data
);

    logic [3:0] avail;
    logic [3:0] space_clamped;

    // Number of words that can be accepted from this block.
    always_comb begin
        avail = 4'(FETCH_WIDTH) - off;
        if (int'(space) > FETCH_WIDTH) begin
            space_clamped = 4'(FETCH_WIDTH);
        end else begin
            space_clamped = 4'(space);
        end
        if (space_clamped < avail) begin
            take = space_clamped;
        end else begin
            take = avail;
        end
    end

    // Word shift by off with zero fill above take.
    always_comb begin
        data = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if ((4'(i) < take) && ((int'(off) + i) < FETCH_WIDTH)) begin
                data[32*i +: 32] = rdata[32*(int'(off) + i) +: 32];
            end else begin
                data[32*i +: 32] = 32'd0;
            end
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: issues one aligned block read at a time at the current PC,
// pushes the useful returned words into the instruction queue and advances the PC by
// exactly the number of words pushed. A redirect squashes the in-flight read.
// Optional build macro FETCH_SEQ_PERF_EN adds saturating perf counters.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   pc, redirect           : PC register value, mispredict redirect
//   imem_addr, imem_rmask  : registered read request (rmask 4'hF while outstanding)
//   imem_rdata, imem_resp  : returned block and completion pulse
//   iq_space               : free queue entries
//   iq_push/count/data/pc  : queue push (combinational in the response cycle)
//   move_pc, move_amount   : PC advance pulse and word count
//   perf_words/squash/stall: (FETCH_SEQ_PERF_EN only) saturating event counters
module fetch_sequencer
    import rv32i_types::*;
#(
    parameter int FETCH_WIDTH = FETCH_BLK_BYTES / 4,
    parameter int SPACE_W     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               pc,
    input  logic                      redirect,
    output logic [31:0]               imem_addr,
    output logic [3:0]                imem_rmask,
    input  logic [32*FETCH_WIDTH-1:0] imem_rdata,
    input  logic                      imem_resp,
    input  logic [SPACE_W-1:0]        iq_space,
    output logic                      iq_push,
    output logic [3:0]                iq_count,
    output logic [32*FETCH_WIDTH-1:0] iq_data,
    output logic [31:0]               iq_pc,
    output logic                      move_pc,
    output logic [3:0]                move_amount
`ifdef FETCH_SEQ_PERF_EN
    ,
    output logic [31:0]               perf_words,
    output logic [31:0]               perf_squash,
    output logic [31:0]               perf_stall
`endif
);

    localparam logic [31:0] ALIGN_MASK = ~32'(FETCH_WIDTH * 4 - 1);

    fetch_state_t              state;
    fetch_state_t              next_state;
    logic [31:0]               issue_pc;
    logic [3:0]                off;
    logic [3:0]                take;
    logic [32*FETCH_WIDTH-1:0] aligned_data;
    logic                      issue;

    assign off = word_offset(issue_pc, FETCH_WIDTH);

    fetch_align #(
        .FETCH_WIDTH (FETCH_WIDTH),
        .SPACE_W     (SPACE_W)
    ) u_align (
        .rdata (imem_rdata),
        .off   (off),
        .space (iq_space),
        .take  (take),
        .data  (aligned_data)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a response always ends the read, redirect only matters before it.
    always_comb begin
        next_state = state;
        issue      = 1'b0;
        case (state)
            IDLE: begin
                if (!redirect && (iq_space != '0)) begin
                    next_state = WAIT;
                    issue      = 1'b1;
                end else begin
                    next_state = IDLE;
                end
            end
            WAIT: begin
                if (imem_resp) begin
                    next_state = IDLE;
                end else if (redirect) begin
                    next_state = SQUASH;
                end else begin
                    next_state = WAIT;
                end
            end
            SQUASH: begin
                if (imem_resp) begin
                    next_state = IDLE;
                end else begin
                    next_state = SQUASH;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Push/move outputs; only a live response (WAIT, no redirect) with take>0 pushes.
    always_comb begin
        iq_push     = 1'b0;
        iq_count    = 4'd0;
        iq_data     = '0;
        iq_pc       = 32'd0;
        move_pc     = 1'b0;
        move_amount = 4'd0;
        if (!rst && (state == WAIT) && imem_resp && !redirect && (take != 4'd0)) begin
            iq_push     = 1'b1;
            iq_count    = take;
            iq_data     = aligned_data;
            iq_pc       = issue_pc;
            move_pc     = 1'b1;
            move_amount = take;
        end else begin
            iq_push     = 1'b0;
        end
    end

    // Request registers: captured at issue, held until the response arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            imem_addr  <= 32'd0;
            imem_rmask <= 4'h0;
            issue_pc   <= 32'd0;
        end else if (issue) begin
            imem_addr  <= pc & ALIGN_MASK;
            imem_rmask <= 4'hF;
            issue_pc   <= pc;
        end else if ((state != IDLE) && imem_resp) begin
            imem_rmask <= 4'h0;
        end else begin
            imem_rmask <= imem_rmask;
        end
    end

`ifdef FETCH_SEQ_PERF_EN
    logic [32:0] words_sum;
    assign words_sum = {1'b0, perf_words} + 33'(iq_count);

    // Saturating perf counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_words  <= 32'd0;
            perf_squash <= 32'd0;
            perf_stall  <= 32'd0;
        end else begin
            if (iq_push) begin
                perf_words <= words_sum[32] ? 32'hFFFF_FFFF : words_sum[31:0];
            end
            if ((state != IDLE) && imem_resp && !iq_push && (perf_squash != 32'hFFFF_FFFF)) begin
                perf_squash <= perf_squash + 32'd1;
            end
            if ((state == IDLE) && !redirect && (iq_space == '0) && (perf_stall != 32'hFFFF_FFFF)) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Fetch-stage controller that sequences the PC register and the instruction-memory port. It issues aligned fetch-block reads at the current PC and pushes the returned words into the instruction queue. It pulses move_pc/move_amount so the PC advances by exactly the number of words accepted. On a branch-mispredict redirect it squashes the in-flight fetch, so stale words never reach the queue.

Parameters:
FETCH_WIDTH, 4, 32-bit words per fetch block; power of two, 1..8
SPACE_W, 4, width of iq_space; must hold values 0..FETCH_WIDTH

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
pc  in  32  current PC register value
redirect  in  1  branch-mispredict redirect; same cycle the PC register loads the target
imem_addr  out  32  fetch-block address, FETCH_WIDTH*4-byte aligned
imem_rmask  out  4  4'hF while a read is outstanding, else 0
imem_rdata  in  32*FETCH_WIDTH  returned block; word i at bits [32i+31:32i]
imem_resp  in  1  read-complete pulse
iq_space  in  SPACE_W  free instruction-queue entries this cycle
iq_push  out  1  push returned words this cycle
iq_count  out  4  number of words pushed, 1..FETCH_WIDTH
iq_data  out  32*FETCH_WIDTH  pushed words, word 0 = instruction at iq_pc, unused upper words zero
iq_pc  out  32  PC of word 0
move_pc  out  1  advance PC register
move_amount  out  4  words to advance (equals iq_count)

Behaviour:
- Reset: state IDLE; imem_addr=0, imem_rmask=0, iq_push=0, iq_count=0, iq_data=0, iq_pc=0, move_pc=0, move_amount=0. Reset mid-fetch drops the outstanding read; the memory side is reset together.
- States: IDLE, WAIT, SQUASH.
- IDLE, with !redirect and iq_space>=1: register imem_addr={pc[31:B],B'0}, where B=log2(FETCH_WIDTH*4). Register issue_pc=pc and rmask=4'hF. Next state WAIT. The request is visible the cycle after the issue decision.
- IDLE with redirect, or with iq_space==0: no issue; stay IDLE.
- WAIT: imem_addr and imem_rmask held stable until imem_resp.
  - On imem_resp with !redirect: off=issue_pc[B-1:2], avail=FETCH_WIDTH-off, take=min(avail, iq_space), with iq_space sampled in the response cycle.
  - If take>0: combinationally assert iq_push=1, move_pc=1, iq_count=move_amount=take, iq_pc=issue_pc. iq_data word i = rdata word off+i for i<take, else 0.
  - If take==0: the response is discarded, no push, no move.
  - rmask cleared; next state IDLE.
- WAIT with redirect and no resp: next state SQUASH; request stays held.
- redirect in the same cycle as imem_resp: response discarded, no push, move_pc=0; next state IDLE.
- SQUASH: hold the request. On imem_resp, discard it, clear rmask and go to IDLE. A redirect while in SQUASH stays in SQUASH.
- move_pc is never asserted in a redirect cycle (redirect has priority at the PC register).
- Arithmetic: take, off and avail are computed in 4 bits; iq_space is clamped to FETCH_WIDTH before the min.
- At most one outstanding read. Minimum loop is 3 cycles per block: issue, request, response in the next cycle.

Optional Feature:
FETCH_SEQ_PERF_EN: adds 32-bit saturating output counters:
- perf_words: words pushed.
- perf_squash: responses discarded.
- perf_stall: IDLE cycles blocked by iq_space==0.
Counters reset to 0. Without the macro these ports and registers do not exist; behaviour is otherwise identical.

Decomposition:
- Shared rv32i_types package: the fetch_state_t enum {IDLE, WAIT, SQUASH} and localparam FETCH_BLK_BYTES.
- Sub-module fetch_align: combinational extract/shift of rdata words by off with zero-fill, plus the take computation.
- The FSM and registers stay in fetch_sequencer.

Test Plan:
- Reset, then pc=0x1eceb000, iq_space=8, FETCH_WIDTH=4 -> request at 0x1eceb000, rmask=F. Resp 1 cycle later -> iq_push, iq_count=4, move_amount=4, iq_pc=0x1eceb000.
- pc=0x1eceb008, iq_space=8 -> addr 0x1eceb000. On resp: iq_count=2, data words = rdata words 2,3, upper zero, iq_pc=0x1eceb008.
- pc=0x1eceb000, iq_space drops to 1 at the resp cycle -> iq_count=1, move_amount=1. Next request at 0x1eceb000 with offset 1.
- Redirect asserted 2 cycles into a WAIT with an 5-cycle memory latency -> SQUASH. Resp discarded, no iq_push/move_pc. Next request uses the redirected pc.
- Redirect in the same cycle as imem_resp -> no push, no move_pc; IDLE next cycle, then issue at the new pc.
- iq_space=0 held 5 cycles in IDLE -> no request, rmask=0. With FETCH_SEQ_PERF_EN, perf_stall=5.
